// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-way RAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    // Port owner: nobody, requester 0 or requester 1 (granted last cycle).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } owner_e;

    // Burst counter must hold the value MAX_BURST itself.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision with a bounded burst for the owner.
// Latency: purely combinational, zero cycles.
// Backpressure: a losing requester simply sees no grant and keeps requesting.
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = burst_cnt_width(MAX_BURST)
) (
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       state,
    input  logic             last,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             gnt0,
    output logic             gnt1
);

    logic budget_left;

    // The owner may keep going while its burst budget is not used up.
    assign budget_left = (burst_cnt < CNT_W'(MAX_BURST));

    // Owner continues unless it dropped or ran out of budget against a waiter;
    // from idle a tie goes to the side that was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            BUSY0: begin
                if (req0 && (budget_left || !req1)) gnt0 = 1'b1;
                else if (req1)                      gnt1 = 1'b1;
            end
            BUSY1: begin
                if (req1 && (budget_left || !req0)) gnt1 = 1'b1;
                else if (req0)                      gnt0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    gnt0 = last;
                    gnt1 = ~last;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between two requesters, round-robin with bounded bursts.
// Latency: grant and RAM access in the request cycle; read data valid one cycle later.
// Backpressure: an ungranted requester holds req and its operands until granted.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUMBER    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [NUMBER-1:0] addr0,
    input  logic [NUMBER-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [NUMBER-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    input  logic [WIDTH-1:0]  ram_rdata
);

    localparam int                CNT_W     = burst_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BURST);
    localparam logic [NUMBER:0]   DEPTH_LIM = (NUMBER + 1)'(DEPTH);

    owner_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic               arb_gnt0, arb_gnt1;
    logic               access;
    logic               sel_we;
    logic [NUMBER-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_wdata;

    rr_arb2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_rr_arb2 (
        .req0      (req0),
        .req1      (req1),
        .state     (state_q),
        .last      (last_q),
        .burst_cnt (burst_cnt_q),
        .gnt0      (arb_gnt0),
        .gnt1      (arb_gnt1)
    );

    // State register; reset leaves req0 winning the first tie and drops any pending read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    // Next owner, burst length and read-return strobes from this cycle's grant.
    always_comb begin
        state_d     = IDLE;
        last_d      = last_q;
        burst_cnt_d = '0;
        if (arb_gnt0) begin
            state_d     = BUSY0;
            last_d      = 1'b0;
            burst_cnt_d = CNT_W'(1);
            if (state_q == BUSY0 && burst_cnt_q != CNT_MAX) burst_cnt_d = burst_cnt_q + CNT_W'(1);
            else if (state_q == BUSY0)                      burst_cnt_d = CNT_MAX;
        end else if (arb_gnt1) begin
            state_d     = BUSY1;
            last_d      = 1'b1;
            burst_cnt_d = CNT_W'(1);
            if (state_q == BUSY1 && burst_cnt_q != CNT_MAX) burst_cnt_d = burst_cnt_q + CNT_W'(1);
            else if (state_q == BUSY1)                      burst_cnt_d = CNT_MAX;
        end
        rvalid0_d = arb_gnt0 & ~we0;
        rvalid1_d = arb_gnt1 & ~we1;
    end

    // Grants, RAM drive and read return; everything is forced quiet while reset is low.
    always_comb begin
        gnt0      = arb_gnt0 & reset_n;
        gnt1      = arb_gnt1 & reset_n;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = we0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end else if (gnt1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
        // A non-power-of-two DEPTH never sees an address past its last word.
        access    = (gnt0 | gnt1) & ({1'b0, sel_addr} < DEPTH_LIM);
        ram_cs_n  = ~access;
        ram_we_n  = ~(access & sel_we);
        ram_addr  = sel_addr;
        ram_wdata = sel_wdata;
        rvalid0   = rvalid0_q;
        rvalid1   = rvalid1_q;
        rdata0    = rvalid0_q ? ram_rdata : '0;
        rdata1    = rvalid1_q ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int NUMBER = 3;
    localparam int MB = 4;

    logic clk, reset_n;
    logic req0, req1, we0, we1;
    logic [NUMBER-1:0] addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic ram_cs_n, ram_we_n;
    logic [NUMBER-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUMBER(NUMBER), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM behind the port: write at the edge, read data one cycle later.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (!ram_we_n) mem[ram_addr] <= ram_wdata;
            else           ram_rdata <= mem[ram_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many grants in a row, who was served last.
    int m_owner, m_streak, m_last, m_g;
    logic m_rv0, m_rv1;
    logic [WIDTH-1:0] m_rd0, m_rd1;
    logic [WIDTH-1:0] shadow [DEPTH];
    logic obs_g0, obs_g1, obs_rv0, obs_rv1;
    logic [WIDTH-1:0] obs_rd0, obs_rd1;

    task automatic m_reset();
        m_owner = -1; m_streak = 0; m_last = 1;
        m_rv0 = 1'b0; m_rv1 = 1'b0;
    endtask

    // Owner keeps the port while it still asks and either has budget or no rival;
    // otherwise the requester served less recently wins.
    function automatic int pick();
        if (m_owner == 0 && req0 && (m_streak < MB || !req1)) return 0;
        if (m_owner == 1 && req1 && (m_streak < MB || !req0)) return 1;
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // One clock: check all outputs mid-cycle against the model, then advance it.
    task automatic step();
        int g;
        @(negedge clk);
        g = pick();
        chk("gnt0", gnt0, g == 0);
        chk("gnt1", gnt1, g == 1);
        chk("ram_cs_n", ram_cs_n, g < 0);
        chk("ram_we_n", ram_we_n, g < 0 ? 1'b1 : (g == 0 ? !we0 : !we1));
        chk("ram_addr", ram_addr, g < 0 ? '0 : (g == 0 ? addr0 : addr1));
        chk("ram_wdata", ram_wdata, g < 0 ? '0 : (g == 0 ? wdata0 : wdata1));
        chk("rvalid0", rvalid0, m_rv0);
        chk("rdata0", rdata0, m_rv0 ? m_rd0 : '0);
        chk("rvalid1", rvalid1, m_rv1);
        chk("rdata1", rdata1, m_rv1 ? m_rd1 : '0);
        obs_g0 = gnt0; obs_g1 = gnt1; obs_rv0 = rvalid0; obs_rv1 = rvalid1;
        obs_rd0 = rdata0; obs_rd1 = rdata1;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_g = g;
        if (g >= 0) begin
            m_streak = (m_owner == g) ? m_streak + 1 : 1;
            m_owner = g; m_last = g;
            if (g == 0) begin
                if (we0) shadow[addr0] = wdata0;
                else begin m_rv0 = 1'b1; m_rd0 = shadow[addr0]; end
            end else begin
                if (we1) shadow[addr1] = wdata1;
                else begin m_rv1 = 1'b1; m_rd1 = shadow[addr1]; end
            end
        end else begin
            m_owner = -1; m_streak = 0;
        end
        @(posedge clk); #1;
    endtask

    // Pulse reset mid-cycle: outputs must go quiet at once, even with requests pending.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_cs_n", ram_cs_n, 1'b1);
        chk("rst_we_n", ram_we_n, 1'b1);
        chk("rst_addr", ram_addr, '0);
        chk("rst_wdata", ram_wdata, '0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_reset();
    endtask

    task automatic new_req0();
        req0 = ($urandom_range(0, 3) != 0); we0 = $urandom_range(0, 1);
        addr0 = NUMBER'($urandom_range(0, DEPTH - 1)); wdata0 = WIDTH'($urandom);
    endtask

    task automatic new_req1();
        req1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1);
        addr1 = NUMBER'($urandom_range(0, DEPTH - 1)); wdata1 = WIDTH'($urandom);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        ram_rdata = '0;
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 3'd5; addr1 = 3'd6; wdata0 = 8'hAA; wdata1 = 8'h55;
        m_reset();
        #3;
        do_reset();

        // Write 5 to addr 1, read it back.
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 8'd5;
        step();
        chk("t1_wr_gnt0", obs_g0, 1'b1);
        we0 = 1'b0;
        step();
        req0 = 1'b0;
        step();
        chk("t1_rvalid0", obs_rv0, 1'b1);
        chk("t1_rdata0", obs_rd0, 8'd5);

        // Tie from idle after reset goes to requester 0.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd4; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd6; wdata1 = 8'h22;
        step();
        chk("t2_tie_gnt0", obs_g0, 1'b1);
        chk("t2_tie_gnt1", obs_g1, 1'b0);
        req0 = 1'b0;
        step();
        chk("t2_then_gnt1", obs_g1, 1'b1);

        // Bounded burst: req0 from cycle 0, req1 from cycle 2.
        do_reset();
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd7; wdata0 = 8'h70;
        we1 = 1'b1; addr1 = 3'd0; wdata1 = 8'h01;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) req1 = 1'b1;
            step();
            chk("t3_burst_gnt0", obs_g0, (c < 4) || (c >= 8));
            chk("t3_burst_gnt1", obs_g1, (c >= 4) && (c < 8));
        end

        // Lone requester keeps the port; burst counter saturates.
        do_reset();
        req0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t4_alone_gnt1", obs_g1, 1'b1);
            chk("t4_burst_cnt", dut.burst_cnt_q, (c + 1 < MB) ? c + 1 : MB);
        end

        // Interleaved reads of addr 2 (12) and addr 3 (36).
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; wdata0 = 8'd12;
        step();
        addr0 = 3'd3; wdata0 = 8'd36;
        step();
        for (int k = 0; k < 9; k++) begin
            req0 = (k < 8) && (k % 2 == 0); we0 = 1'b0; addr0 = 3'd2;
            req1 = (k < 8) && (k % 2 == 1); we1 = 1'b0; addr1 = 3'd3;
            step();
            if (k > 0) begin
                chk("t5_rvalid0", obs_rv0, k % 2 == 1);
                chk("t5_rvalid1", obs_rv1, k % 2 == 0);
                chk("t5_rdata0", obs_rd0, (k % 2 == 1) ? 8'd12 : 8'd0);
                chk("t5_rdata1", obs_rd1, (k % 2 == 0) ? 8'd36 : 8'd0);
            end
        end

        // Reset during a read burst while rvalid0 is pending.
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
        step();
        step();
        chk("t6_pending_rv0", rvalid0, 1'b1);
        do_reset();
        req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
        step();
        chk("t6_after_gnt0", obs_g0, 1'b1);
        chk("t6_after_gnt1", obs_g1, 1'b0);

        // Random traffic: operands held until granted, new request afterwards.
        new_req0();
        new_req1();
        for (int c = 0; c < 600; c++) begin
            step();
            if (m_g == 0 || !req0) new_req0();
            if (m_g == 1 || !req1) new_req1();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Single-clock arbiter that shares one synchronous RAM access port (chip-select, write-enable, address, write data, read data) between two requesters. Arbitration is round-robin with bounded bursts: the current owner keeps the port for up to MAX_BURST consecutive cycles while the other side waits. The block sits between two client engines and the `ram_double` storage. It drives the RAM's active-low select and write-enable and returns read data with a valid strobe.

## Interface
- WIDTH, 8, data width
- DEPTH, 8, RAM words
- NUMBER, 3, address bits (DEPTH = 2**NUMBER)
- MAX_BURST, 4, max consecutive grants to one owner while the other requests; minimum 1
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  NUMBER  word address
- wdata0 / wdata1  in  WIDTH  write data
- gnt0 / gnt1  out  1  access performed at this clock edge
- rvalid0 / rvalid1  out  1  rdata valid this cycle
- rdata0 / rdata1  out  WIDTH  read data
- ram_cs_n  out  1  RAM select, active low
- ram_we_n  out  1  RAM write enable, active low
- ram_addr  out  NUMBER  RAM address
- ram_wdata  out  WIDTH  RAM write data
- ram_rdata  in  WIDTH  RAM read data, valid one cycle after a read select

## Operation
- Registered state:
  - owner FSM with states IDLE, BUSY0, BUSY1
  - last pointer (last served requester)
  - burst_cnt, width $clog2(MAX_BURST+1)
  - rvalid0 and rvalid1
- Grant decision is combinational from the req inputs and registered state. At most one grant per cycle.
- State IDLE:
  - one request → grant it
  - both request → grant the one that is not `last`
- State BUSYi:
  - req_i high and (burst_cnt < MAX_BURST or req of the other side low) → grant i
  - otherwise, other side requesting → grant the other side
  - otherwise → no grant
- Next state:
  - gnt_i → BUSYi and last = i
  - no grant → IDLE, last retained
- burst_cnt:
  - set to 1 on a switch or on a grant from IDLE
  - incremented on a continued grant
  - saturates at MAX_BURST
  - cleared in IDLE
- RAM drive:
  - ram_cs_n = ~(gnt0 | gnt1)
  - ram_we_n = ~(granted we); 1 when idle
  - ram_addr and ram_wdata are muxed from the granted side; 0 when idle
- Read return:
  - rvalid_i is registered and set for exactly one cycle after a read grant to i
  - rdata_i = ram_rdata when rvalid_i is high, else 0
- MAX_BURST = 1 gives strict alternation under continuous contention.
- Requester signals we/addr/wdata must stay stable while req is high and not yet granted. The arbiter does not capture them.

## Timing
- Grant latency is zero cycles: with the port free, req in cycle n gives gnt in cycle n, and the write lands at the edge ending cycle n.
- Read latency is one cycle: rvalid and rdata are present in cycle n+1.
- Worst-case wait under contention is MAX_BURST cycles.
- Back-to-back reads from the same side give rvalid every cycle.
- A switch between requesters has no bubble cycle.
- Reset values: state IDLE, last = 1 (so req0 wins the first tie), burst_cnt = 0, rvalid0/1 = 0, rdata0/1 = 0.
- While reset_n is low: gnt0/1 = 0, ram_cs_n = 1, ram_we_n = 1, ram_addr = 0, ram_wdata = 0.
- Reset mid-burst: the pending rvalid is discarded and the state returns to IDLE asynchronously.
- req dropped mid-burst: no grant that cycle. If the other side is requesting, it is granted in that same cycle.

## Structure
- Package ram_arb_pkg holds:
  - owner state encoding: IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2
  - function computing the burst counter width
- One sub-module, rr_arb2: purely combinational 2-way decision logic (reqs, state, last, burst_cnt → gnt0/gnt1).
- The top level holds the registers, the RAM mux and read-return logic.

## Test plan
- Reset release, req0 writes 5 to addr 1, then reads addr 1 → gnt0 in the same cycle, ram_we_n = 0, ram_addr = 1; on the read, rvalid0 one cycle later with rdata0 = 5.
- Both requesting from IDLE after reset → gnt0 first (last = 1), and gnt1 never in the same cycle as gnt0.
- MAX_BURST = 4, req0 continuous from cycle 0, req1 raised in cycle 2 → gnt0 in cycles 0–3, gnt1 in cycle 4, back to gnt0 after MAX_BURST grants to 1 if req0 is still high.
- req1 alone for 10 cycles → gnt1 all 10 cycles (no forced switch), burst_cnt saturates at 4.
- Reads interleaved: req0 reads addr 2 (data 12), req1 reads addr 3 (data 36) alternating → rvalid0/rdata0 = 12 and rvalid1/rdata1 = 36, each exactly one cycle after its own grant.
- reset_n pulsed low during a read burst → rvalid cleared, ram_cs_n = 1 immediately; after release, state is IDLE and req0 wins the tie.
